// File: rtl/trace_axis_width_converter.sv
// Serialises wide trace packets into OUT_WIDTH-bit AXI-Stream beats, LSB beat first.
// An active/pending buffer pair lets the next packet land while the current one drains.
module trace_axis_width_converter #(
  parameter int unsigned IN_WIDTH  = 512,
  parameter int unsigned OUT_WIDTH = 64,
  localparam int unsigned BEATS    = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH,
  localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tlast,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tlast,
  output logic [31:0]          words_forwarded,
  output logic [CNT_W-1:0]     beat_index
);

  localparam int unsigned PAD_W = BEATS * OUT_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [PAD_W-1:0]   act_data_q, act_data_d;
  logic               act_last_q, act_last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAD_W-1:0]   pend_data_q, pend_data_d;
  logic               pend_last_q, pend_last_d;
  logic               pend_valid_q, pend_valid_d;
  logic               s_ready_q;
  logic               m_valid_q;
  logic               m_last_q, m_last_d;
  logic [31:0]        words_q, words_d;

  logic               in_hs;
  logic               out_hs;
  logic               last_beat;
  logic               take_in;
  logic [PAD_W-1:0]   in_pad;

  assign in_pad    = PAD_W'(S_AXIS_tdata);
  assign in_hs     = S_AXIS_tvalid & s_ready_q;
  assign out_hs    = m_valid_q & M_AXIS_tready;
  assign last_beat = (cnt_q == LAST_CNT);

  // The active buffer shifts right per beat, so the low slice is always the beat on the wire.
  assign M_AXIS_tdata    = act_data_q[OUT_WIDTH-1:0];
  assign M_AXIS_tvalid   = m_valid_q;
  assign M_AXIS_tlast    = m_last_q;
  assign S_AXIS_tready   = s_ready_q;
  assign words_forwarded = words_q;
  assign beat_index      = cnt_q;

  // Next-state, buffer steering and output look-ahead.
  always_comb begin
    state_d      = state_q;
    act_data_d   = act_data_q;
    act_last_d   = act_last_q;
    cnt_d        = cnt_q;
    pend_data_d  = pend_data_q;
    pend_last_d  = pend_last_q;
    pend_valid_d = pend_valid_q;
    words_d      = words_q;
    take_in      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_hs) begin
          take_in = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_hs) begin
          if (!last_beat) begin
            cnt_d      = CNT_W'(cnt_q + 1'b1);
            act_data_d = act_data_q >> OUT_WIDTH;
          end else begin
            words_d = words_q + 32'd1;
            if (pend_valid_q) begin
              act_data_d   = pend_data_q;
              act_last_d   = pend_last_q;
              cnt_d        = '0;
              pend_valid_d = 1'b0;
            end else if (in_hs) begin
              take_in = 1'b1;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted packet goes straight to active when it is free, else to pending.
    if (take_in) begin
      act_data_d = in_pad;
      act_last_d = S_AXIS_tlast;
      cnt_d      = '0;
    end else if (in_hs) begin
      pend_data_d  = in_pad;
      pend_last_d  = S_AXIS_tlast;
      pend_valid_d = 1'b1;
    end

    m_last_d = (state_d == SEND) & act_last_d & (cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      act_data_q   <= '0;
      act_last_q   <= 1'b0;
      cnt_q        <= '0;
      pend_data_q  <= '0;
      pend_last_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      words_q      <= '0;
    end else begin
      state_q      <= state_d;
      act_data_q   <= act_data_d;
      act_last_q   <= act_last_d;
      cnt_q        <= cnt_d;
      pend_data_q  <= pend_data_d;
      pend_last_q  <= pend_last_d;
      pend_valid_q <= pend_valid_d;
      s_ready_q    <= ~pend_valid_d;
      m_valid_q    <= (state_d == SEND);
      m_last_q     <= m_last_d;
      words_q      <= words_d;
    end
  end

endmodule

// File: tb/tb_trace_axis_width_converter.sv
// Randomised checks of the trace width converter against a packet/beat queue model,
// plus directed checks of the 100->64 and 64->64 configurations.
module tb_trace_axis_width_converter;

  logic         clk;
  logic         rst_n;

  logic         s_tvalid, s_tready, s_tlast;
  logic [511:0] s_tdata;
  logic         m_tvalid, m_tready, m_tlast;
  logic [63:0]  m_tdata;
  logic [31:0]  words;
  logic [2:0]   bidx;

  logic         a_tvalid, a_tready, a_tlast;
  logic [99:0]  a_tdata;
  logic         a_m_tvalid, a_m_tready, a_m_tlast;
  logic [63:0]  a_m_tdata;
  logic [31:0]  a_words;
  logic [0:0]   a_bidx;

  logic         b_tvalid, b_tready, b_tlast;
  logic [63:0]  b_tdata;
  logic         b_m_tvalid, b_m_tready, b_m_tlast;
  logic [63:0]  b_m_tdata;
  logic [31:0]  b_words;
  logic [0:0]   b_bidx;

  trace_axis_width_converter #(.IN_WIDTH(512), .OUT_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(s_tvalid), .S_AXIS_tready(s_tready), .S_AXIS_tdata(s_tdata), .S_AXIS_tlast(s_tlast),
    .M_AXIS_tvalid(m_tvalid), .M_AXIS_tready(m_tready), .M_AXIS_tdata(m_tdata), .M_AXIS_tlast(m_tlast),
    .words_forwarded(words), .beat_index(bidx)
  );

  trace_axis_width_converter #(.IN_WIDTH(100), .OUT_WIDTH(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(a_tvalid), .S_AXIS_tready(a_tready), .S_AXIS_tdata(a_tdata), .S_AXIS_tlast(a_tlast),
    .M_AXIS_tvalid(a_m_tvalid), .M_AXIS_tready(a_m_tready), .M_AXIS_tdata(a_m_tdata), .M_AXIS_tlast(a_m_tlast),
    .words_forwarded(a_words), .beat_index(a_bidx)
  );

  trace_axis_width_converter #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(b_tvalid), .S_AXIS_tready(b_tready), .S_AXIS_tdata(b_tdata), .S_AXIS_tlast(b_tlast),
    .M_AXIS_tvalid(b_m_tvalid), .M_AXIS_tready(b_m_tready), .M_AXIS_tdata(b_m_tdata), .M_AXIS_tlast(b_m_tlast),
    .words_forwarded(b_words), .beat_index(b_bidx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // Model: queue of {tlast, data} beats still owed, packets held, beats/packets delivered.
  logic [64:0]  expq[$];
  int unsigned  inflight = 0;
  int unsigned  sent = 0;
  logic [31:0]  completed = '0;
  logic         armed = 1'b0;
  logic         bp_mode = 1'b0;
  int unsigned  rdy_low = 0;
  int unsigned  tl_count = 0;
  int unsigned  tl_beat = 0;
  int unsigned  test_beats = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Check the main DUT against the model, account this cycle's handshakes, advance one clock.
  task automatic cycle();
    logic        in_hs, out_hs;
    logic [64:0] fr;
    logic [63:0] bt;
    logic [511:0] sh;
    if (bp_mode) m_tready = 1'($urandom_range(0, 1));
    in_hs  = s_tvalid && s_tready;
    out_hs = m_tvalid && m_tready;
    chk("s_tready", 512'(s_tready), 512'(armed && (inflight < 2)));
    chk("m_tvalid", 512'(m_tvalid), 512'(inflight > 0));
    chk("words_forwarded", 512'(words), 512'(completed));
    chk("beat_index", 512'(bidx), 512'(sent % 8));
    if (!s_tready) rdy_low++;
    if (m_tvalid && expq.size() > 0) begin
      fr = expq[0];
      chk("m_tdata", 512'(m_tdata), 512'(fr[63:0]));
      chk("m_tlast", 512'(m_tlast), 512'(fr[64]));
    end
    if (out_hs && expq.size() > 0) begin
      void'(expq.pop_front());
      if (m_tlast) begin
        tl_count++;
        tl_beat = test_beats;
      end
      test_beats++;
      sent++;
      if (sent % 8 == 0) begin
        completed = completed + 32'd1;
        inflight--;
      end
    end
    if (in_hs) begin
      for (int k = 0; k < 8; k++) begin
        sh = s_tdata >> (64 * k);
        bt = sh[63:0];
        expq.push_back({s_tlast && (k == 7), bt});
      end
      inflight++;
    end
    @(posedge clk);
    #1;
    armed = rst_n;
  endtask

  // Offer a packet until accepted; leaves tvalid high for back-to-back use.
  task automatic push(input logic [511:0] d, input logic l);
    bit got;
    got = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    for (int i = 0; i < 300; i++) begin
      got = s_tready;
      cycle();
      if (got) break;
    end
    chk("push_accept", 512'(got), 512'(1));
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    for (int i = 0; i < 1000 && inflight > 0; i++) cycle();
    chk("drain_done", 512'(inflight), 512'(0));
    cycle();
  endtask

  logic [511:0] pk;
  logic [127:0] r128;
  logic [99:0]  pa;
  logic [63:0]  pb[3];
  int unsigned  base;

  initial begin
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
    a_tvalid = 1'b0; a_tdata = '0; a_tlast = 1'b0; a_m_tready = 1'b1;
    b_tvalid = 1'b0; b_tdata = '0; b_tlast = 1'b0; b_m_tready = 1'b1;
    #12;
    chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
    chk("rst_m_tdata", 512'(m_tdata), 512'(0));
    chk("rst_m_tlast", 512'(m_tlast), 512'(0));
    chk("rst_words", 512'(words), 512'(0));
    chk("rst_beat_index", 512'(bidx), 512'(0));
    chk("rst_s_tready", 512'(s_tready), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    armed = 1'b0;
    cycle();

    // Single known packet, continuous ready.
    for (int k = 0; k < 8; k++)
      pk[k*64 +: 64] = 64'h1111_0000_0000_0000 * 64'(k + 1) + 64'(k);
    tl_count = 0; test_beats = 0;
    push(pk, 1'b1);
    drain();
    chk("t1_words", 512'(words), 512'(1));
    chk("t1_tlast_count", 512'(tl_count), 512'(1));
    chk("t1_tlast_beat", 512'(tl_beat), 512'(7));

    // Back-to-back packets with tvalid held.
    rdy_low = 0;
    for (int i = 0; i < 4; i++) push(rnd512(), 1'($urandom_range(0, 1)));
    drain();
    chk("t2_words", 512'(words), 512'(5));
    chk("t2_ready_dropped", 512'(rdy_low > 0), 512'(1));

    // Random backpressure.
    bp_mode = 1'b1;
    for (int i = 0; i < 3; i++) push(rnd512(), 1'b1);
    drain();
    bp_mode = 1'b0;
    m_tready = 1'b1;
    chk("t3_words", 512'(words), 512'(8));

    // tlast gating across 0,1,0 packets.
    tl_count = 0; test_beats = 0;
    push(rnd512(), 1'b0);
    push(rnd512(), 1'b1);
    push(rnd512(), 1'b0);
    drain();
    chk("t4_tlast_count", 512'(tl_count), 512'(1));
    chk("t4_tlast_beat", 512'(tl_beat), 512'(15));

    // Reset after beat 3 of a packet.
    base = sent;
    push(rnd512(), 1'b1);
    s_tvalid = 1'b0;
    for (int i = 0; i < 50 && sent < base + 4; i++) cycle();
    chk("t5_reached_beat4", 512'(sent - base), 512'(4));
    rst_n = 1'b0;
    #1;
    chk("t5_async_tvalid", 512'(m_tvalid), 512'(0));
    chk("t5_words", 512'(words), 512'(0));
    chk("t5_beat_index", 512'(bidx), 512'(0));
    chk("t5_s_tready", 512'(s_tready), 512'(0));
    expq.delete();
    inflight = 0; sent = 0; completed = '0; armed = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    push(rnd512(), 1'b1);
    drain();
    chk("t5_words_after", 512'(words), 512'(1));

    // 100 -> 64: two beats, top 28 bits of beat 1 zero.
    r128 = {$urandom, $urandom, $urandom, $urandom};
    pa = r128[99:0];
    a_tdata = pa; a_tvalid = 1'b1; a_tlast = 1'b1;
    chk("a_s_tready", 512'(a_tready), 512'(1));
    cycle();
    a_tvalid = 1'b0;
    chk("a_beat0_valid", 512'(a_m_tvalid), 512'(1));
    chk("a_beat0_data", 512'(a_m_tdata), 512'(pa[63:0]));
    chk("a_beat0_last", 512'(a_m_tlast), 512'(0));
    chk("a_beat0_index", 512'(a_bidx), 512'(0));
    cycle();
    chk("a_beat1_data", 512'(a_m_tdata), 512'(pa[99:64]));
    chk("a_beat1_last", 512'(a_m_tlast), 512'(1));
    chk("a_beat1_index", 512'(a_bidx), 512'(1));
    cycle();
    chk("a_idle_valid", 512'(a_m_tvalid), 512'(0));
    chk("a_words", 512'(a_words), 512'(1));

    // 64 -> 64 pass-through, back-to-back, latency 1.
    for (int i = 0; i < 3; i++) begin
      pb[i] = {$urandom, $urandom};
      b_tdata = pb[i]; b_tlast = 1'(i % 2); b_tvalid = 1'b1;
      chk("b_s_tready", 512'(b_tready), 512'(1));
      cycle();
      chk("b_valid", 512'(b_m_tvalid), 512'(1));
      chk("b_data", 512'(b_m_tdata), 512'(pb[i]));
      chk("b_last", 512'(b_m_tlast), 512'(i % 2));
    end
    b_tvalid = 1'b0;
    cycle();
    chk("b_idle_valid", 512'(b_m_tvalid), 512'(0));
    chk("b_words", 512'(b_words), 512'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_axis_width_converter.md
Name: trace_axis_width_converter

Overview:
Downstream stage of the continuous monitoring system. It takes the wide trace-packet AXI-Stream (one packet per traced instruction: performance counters, PC, clock delta, instruction) and serialises each packet into OUT_WIDTH-bit beats for the narrow DMA/FIFO stream into PS memory. A two-entry buffer (active plus pending) lets the next packet be accepted while the current one is still being serialised, so back-to-back packets stream with no idle beats.

Parameters:
IN_WIDTH, 512, width of the input packet (set to AXI_DATA_WIDTH at instantiation)
OUT_WIDTH, 64, width of one output beat
BEATS, ceil(IN_WIDTH/OUT_WIDTH) (derived localparam), output beats per input packet; 8 at defaults

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
S_AXIS_tvalid  input  1  input packet valid
S_AXIS_tready  output  1  input ready
S_AXIS_tdata  input  IN_WIDTH  input packet
S_AXIS_tlast  input  1  packet closes a DMA transfer
M_AXIS_tvalid  output  1  output beat valid
M_AXIS_tready  input  1  downstream ready
M_AXIS_tdata  output  OUT_WIDTH  output beat
M_AXIS_tlast  output  1  last beat of a tlast packet
words_forwarded  output  32  count of fully sent packets
beat_index  output  $clog2(BEATS) (min 1)  index of the current beat in its packet

Behaviour:
- One clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0.
  - words_forwarded=0, beat_index=0.
  - Active and pending buffers empty; state IDLE.
  - S_AXIS_tready=1 one cycle after rst_n deasserts; it is 0 while rst_n is low.
- Packing:
  - The input packet is zero-extended to BEATS*OUT_WIDTH.
  - Beat k = bits [k*OUT_WIDTH +: OUT_WIDTH]. Least-significant beat is sent first.
- Storage: active register (packet, tlast, beat_cnt) and pending register (packet, tlast, valid).
- S_AXIS_tready = ~pending_valid, driven from a register only, with no combinational path from M_AXIS_tready.
- An input handshake is S_AXIS_tvalid & S_AXIS_tready in the same cycle.
- State machine:
  - IDLE: M_AXIS_tvalid=0. On an input handshake, load active, set beat_cnt=0 and go to SEND. The first beat is valid in the next cycle (latency 1).
  - SEND: M_AXIS_tvalid=1. M_AXIS_tdata = active beat beat_cnt. M_AXIS_tlast = active_tlast & (beat_cnt==BEATS-1).
    - Output handshake with beat_cnt<BEATS-1: beat_cnt+1.
    - Output handshake with beat_cnt==BEATS-1: words_forwarded+1 (wraps modulo 2^32). Then:
      a) pending valid: move pending to active, beat_cnt=0, clear pending, stay SEND;
      b) else if an input handshake occurs in the same cycle: load the input into active, beat_cnt=0, stay SEND;
      c) else go to IDLE.
    - Input handshake in SEND, not case b: store the input in pending.
- Stall: while M_AXIS_tvalid=1 and M_AXIS_tready=0, M_AXIS_tdata and M_AXIS_tlast hold stable and beat_cnt holds.
- Full: both buffers occupied gives S_AXIS_tready=0. Upstream holds its packet; no packet is ever dropped or overwritten.
- Throughput: with continuous M_AXIS_tready=1, one beat per cycle, including across packet boundaries.
- beat_index mirrors beat_cnt. It is 0 in IDLE.
- OUT_WIDTH >= IN_WIDTH gives BEATS=1: pass-through with a 1-cycle register stage; tlast is copied.
- Reset mid-packet: buffers are cleared immediately and the partial packet is discarded. words_forwarded=0. Output starts again from beat 0 of the next accepted packet.

Test Plan:
1. Single packet: IN=512, OUT=64, tdata={8{...}} with beat k = 64'h1111_0000_0000_0000*(k+1)+k, tlast=1, M_AXIS_tready=1 -> 8 beats in consecutive cycles starting 1 cycle after acceptance, in order beat0..beat7. M_AXIS_tlast=1 only on beat 7. words_forwarded=1.
2. Back-to-back: 4 packets, S_AXIS_tvalid held high, M_AXIS_tready=1 -> 32 contiguous beats with no tvalid gap. S_AXIS_tready drops while pending is full. words_forwarded=4.
3. Backpressure: M_AXIS_tready toggling 1,0,0,1,... with a random pattern, 3 packets -> all 24 beats delivered in order. Data and tlast are stable during every stall. Third packet held (tready=0) until pending frees.
4. tlast gating: packets with tlast=0,1,0 -> M_AXIS_tlast asserted exactly once, on beat 15 (second packet's final beat).
5. Reset mid-packet: assert rst_n=0 after beat 3 -> M_AXIS_tvalid=0 asynchronously and words_forwarded=0. After release, a new packet is sent starting at beat 0; no remnant beats of the old packet appear.
6. Width edge: IN_WIDTH=100, OUT_WIDTH=64 -> 2 beats. Beat 1 upper 28 bits are 0. Also IN_WIDTH=OUT_WIDTH=64 -> pass-through, one beat per packet, latency 1.
